// File: rtl/arbiter8_rr.sv
`default_nettype none
// ============================================================================
//  Module      : arbiter8_rr
//  Description : 8-way round-robin arbiter with a bounded hold time.
//                A requester keeps its grant until it signals done, drops
//                its request, or has held the grant for HOLD_MAX cycles.
//                Every release is followed by exactly one idle GAP cycle
//                before the next arbitration takes effect.
//
//  Ports
//    clk        in   1  clock, all state changes on the rising edge
//    rst_n      in   1  asynchronous active-low reset
//    req        in   8  request vector, req[7-i] is requester index i
//    done       in   1  current owner finished (looked at only in GRANT)
//    gnt        out  8  registered one-hot grant, same mapping as req
//    gnt_valid  out  1  high exactly when gnt is non-zero
//    gnt_idx    out  3  encoded owner index, 0 when no grant
//    timeout    out  1  one-cycle pulse when the hold limit revoked a grant
//
//  Parameters
//    HOLD_MAX   maximum consecutive grant cycles, legal range 1..255
//
//  Revision    : 1.0  initial release
// ============================================================================
module arbiter8_rr #(
  parameter int HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic       timeout
);

  // Hold counter value on the last permitted grant cycle.
  localparam logic [7:0] C_HOLD_LAST = 8'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [7:0] r_hold;
  logic [7:0] w_hold_nxt;
  logic [7:0] r_gnt;
  logic [7:0] w_gnt_nxt;
  logic [2:0] r_idx;
  logic [2:0] w_idx_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;

  // Requests re-ordered so that bit i belongs to requester index i.
  logic [7:0] w_req_idx;
  logic       w_win_found;
  logic [2:0] w_win_idx;
  logic [7:0] w_win_onehot;
  logic       w_owner_req;
  logic       w_hold_last;
  logic       w_release;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_req_map
      assign w_req_idx[gi] = req[7-gi];
    end
  endgenerate

  // 3-bit wrap-around offset from the pointer.
  function automatic logic [2:0] f_wrap(input logic [2:0] base, input int k);
    return base + 3'(k);
  endfunction

  // Search starts just after the last winner, so the previous owner is
  // always the last candidate considered (offset 8 wraps to ptr itself).
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      if (!w_win_found && w_req_idx[f_wrap(r_ptr, k)]) begin
        w_win_found = 1'b1;
        w_win_idx   = f_wrap(r_ptr, k);
      end
    end
  end

  // Index 0 maps to bit 7, hence the right shift from the MSB.
  assign w_win_onehot = 8'h80 >> w_win_idx;

  // In GRANT the pointer always equals the current owner index.
  assign w_owner_req = w_req_idx[r_ptr];
  assign w_hold_last = (r_hold == C_HOLD_LAST);
  assign w_release   = done || !w_owner_req || w_hold_last;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 3'b111;
      r_hold    <= 8'd0;
      r_gnt     <= 8'h00;
      r_idx     <= 3'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_gnt     <= w_gnt_nxt;
      r_idx     <= w_idx_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and registered-output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_gnt_nxt     = r_gnt;
    w_idx_nxt     = r_idx;
    w_timeout_nxt = 1'b0;

    case (r_state)
      ST_IDLE, ST_GAP: begin
        // done is deliberately not looked at here.
        w_gnt_nxt  = 8'h00;
        w_idx_nxt  = 3'd0;
        w_hold_nxt = 8'd0;
        if (w_win_found) begin
          w_state_nxt = ST_GRANT;
          w_gnt_nxt   = w_win_onehot;
          w_idx_nxt   = w_win_idx;
          w_ptr_nxt   = w_win_idx;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_GRANT: begin
        if (w_release) begin
          // All release causes merge into one GAP; timeout only flags a
          // revocation the owner did not ask for itself.
          w_state_nxt   = ST_GAP;
          w_gnt_nxt     = 8'h00;
          w_idx_nxt     = 3'd0;
          w_hold_nxt    = 8'd0;
          w_timeout_nxt = w_hold_last && !done && w_owner_req;
        end else begin
          w_hold_nxt = r_hold + 8'd1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 8'h00;
        w_idx_nxt   = 3'd0;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_idx   = r_idx;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire
